// File: rtl/rom_seq_pkg.sv
// Shared types and constants for the ROM weight sequencer.
package rom_seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } seq_state_e;

  localparam int unsigned BUF_DEPTH = 2;

  // Width of a counter that must hold every value 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rom_weight_sequencer_fifo.sv
// Two-entry output buffer between the ROM return path and the consumer.
// Ports: clk, reset (sync, active-high), enq_valid/enq_data (write),
// deq_ready (consumer accept), valid/data (head entry), occ (0..2).
module fifo_2entry
  import rom_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_valid,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] mem [BUF_DEPTH];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       occ_q;
  logic             deq;

  assign valid = (occ_q != 2'd0);
  assign data  = mem[rd_ptr];
  assign occ   = occ_q;
  assign deq   = valid && deq_ready;

  // Overflow is prevented upstream by the issue credit check.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ_q  <= '0;
    end else begin
      if (enq_valid) begin
        mem[wr_ptr] <= enq_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end
      if (enq_valid && !deq) begin
        occ_q <= occ_q + 2'd1;
      end else if (!enq_valid && deq) begin
        occ_q <= occ_q - 2'd1;
      end
    end
  end

endmodule

// File: rtl/rom_weight_sequencer.sv
// Sequences one pass of NUM_WORDS reads from a 1-cycle-latency ROM starting
// at BASE_ADDR and streams the words out over valid/ready.
// Ports: clk_i, reset_i, start_i, busy_o, done_o, rom_addr_o, rom_data_i,
// data_o, valid_o, ready_i, last_o.
module rom_weight_sequencer
  import rom_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned WORD_SIZE  = 8,
  parameter int unsigned NUM_WORDS  = 5,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [WORD_SIZE-1:0]  rom_data_i,
  output logic [WORD_SIZE-1:0]  data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o
);

  localparam int unsigned CW = cnt_width(NUM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [CW-1:0] LAST_IDX  = CW'(NUM_WORDS - 1);
  localparam logic [CW-1:0] WORDS_CNT = CW'(NUM_WORDS);

  if (NUM_WORDS < 1 || (BASE_ADDR + NUM_WORDS) > (2 ** ADDR_WIDTH)) begin : g_param_check
    $error("rom_weight_sequencer: pass does not fit in the ROM address space");
  end

  seq_state_e    state_q;
  seq_state_e    state_d;
  logic [CW-1:0] issued_q;
  logic [CW-1:0] accepted_q;
  logic          inflight_q;
  logic          done_q;
  logic [1:0]    occ;
  logic [2:0]    credit;
  logic          issue;
  logic          deq;
  logic          start_acc;
  logic          pass_end;

  fifo_2entry #(
    .WIDTH(WORD_SIZE)
  ) u_buf (
    .clk       (clk_i),
    .reset     (reset_i),
    .enq_valid (inflight_q),
    .enq_data  (rom_data_i),
    .deq_ready (ready_i),
    .valid     (valid_o),
    .data      (data_o),
    .occ       (occ)
  );

  assign deq        = valid_o && ready_i;
  assign busy_o     = (state_q == FETCH);
  assign done_o     = done_q;
  assign last_o     = valid_o && (accepted_q == LAST_IDX);
  assign rom_addr_o = BASE + ADDR_WIDTH'(issued_q);

  // Buffer slots already promised: held words plus the one in flight,
  // minus the one leaving this cycle.
  assign credit = 3'(occ) + 3'(inflight_q) - 3'(deq);
  assign issue  = (state_q == FETCH) && (issued_q < WORDS_CNT) && (credit < 3'd2);

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    pass_end  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = FETCH;
          start_acc = 1'b1;
        end
      end
      FETCH: begin
        if (deq && (accepted_q == LAST_IDX)) begin
          state_d  = IDLE;
          pass_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      issued_q   <= '0;
      accepted_q <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      done_q     <= pass_end;
      if (start_acc) begin
        issued_q   <= '0;
        accepted_q <= '0;
      end else begin
        if (issue) begin
          issued_q <= issued_q + CW'(1);
        end
        if (deq) begin
          accepted_q <= accepted_q + CW'(1);
        end
      end
    end
  end

endmodule
